// File: rtl/apb_timer_pkg.sv
// Shared constants for the APB timer: register byte offsets and CTRL/STATUS bit positions.
// The optional capture feature is enabled with the APB_TIMER_CAPTURE_EN macro.
package apb_timer_pkg;

    localparam int unsigned REG_WIDTH = 32;
    localparam int unsigned OFF_WIDTH = 5;

    // Byte offsets of the register map (paddr[4:2] selects the word)
    localparam logic [OFF_WIDTH-1:0] OFF_CTRL     = 5'h00;
    localparam logic [OFF_WIDTH-1:0] OFF_PRESCALE = 5'h04;
    localparam logic [OFF_WIDTH-1:0] OFF_COMPARE  = 5'h08;
    localparam logic [OFF_WIDTH-1:0] OFF_COUNT    = 5'h0C;
    localparam logic [OFF_WIDTH-1:0] OFF_STATUS   = 5'h10;
    localparam logic [OFF_WIDTH-1:0] OFF_CAPTURE  = 5'h14;

    // CTRL bit positions
    localparam int unsigned CTRL_ENABLE      = 0;
    localparam int unsigned CTRL_AUTO_RELOAD = 1;
    localparam int unsigned CTRL_IRQ_EN      = 2;
    localparam int unsigned CTRL_WIDTH       = 3;

    // STATUS bit positions
    localparam int unsigned STATUS_MATCH   = 0;
    localparam int unsigned STATUS_CAPTURE = 1;

endpackage

// File: rtl/apb_timer_prescaler.sv
// Prescaler for the APB timer: counts 0..prescale while enabled and flags the terminal cycle.
// The tick output is combinational so the main counter advances in the terminal cycle itself.
module apb_timer_prescaler #(
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable_i,
    input  logic                      clear_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    output logic                      tick_o
);

    localparam int unsigned PW = PRESCALE_WIDTH;

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    // >= rather than == so a PRESCALE lowered below the running count ends the period at once
    assign tick_o = enable_i && (cnt_q >= prescale_i);

    // Next prescale count: restart on tick, clear when disabled or when COUNT is loaded
    always_comb begin
        cnt_d = cnt_q + PW'(1);
        if (!enable_i || clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // Prescale count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_timer.sv
// APB3 timer/compare peripheral: prescaled up-counter, compare match with auto-reload or
// one-shot, level IRQ, zero-wait-state register access with pslverror on bad accesses.
// Define APB_TIMER_CAPTURE_EN to add the capture_in port and the CAPTURE register at 0x14.
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned BUS_WIDTH      = 4,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] s_apb_paddr,
    input  logic                     s_apb_psel,
    input  logic                     s_apb_penable,
    output logic                     s_apb_pready,
    input  logic                     s_apb_pwrite,
    input  logic [BUS_WIDTH*8-1:0]   s_apb_pwdata,
    output logic [BUS_WIDTH*8-1:0]   s_apb_prdata,
    output logic                     s_apb_pslverror,
`ifdef APB_TIMER_CAPTURE_EN
    input  logic                     capture_in,
`endif
    output logic                     irq
);

    // Registers are 32 bits wide; only BUS_WIDTH == 4 is a supported configuration
    localparam int unsigned DW = BUS_WIDTH * 8;
    localparam int unsigned PW = PRESCALE_WIDTH;
`ifdef APB_TIMER_CAPTURE_EN
    localparam bit CAPTURE_EN = 1'b1;
`else
    localparam bit CAPTURE_EN = 1'b0;
`endif

    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [PW-1:0]         prescale_q, prescale_d;
    logic [DW-1:0]         compare_q, compare_d;
    logic [DW-1:0]         count_q, count_d;
    logic                  match_q, match_d;
    logic [DW-1:0]         prdata_q;
    logic                  pslverror_q;
    logic                  irq_q, irq_d;

    logic [OFF_WIDTH-1:0]  offset_c;
    logic                  aligned_c;
    logic                  mapped_c;
    logic                  err_c;
    logic                  wr_en_c;
    logic                  status_w1c_c;
    logic                  count_load_c;
    logic                  tick_c;
    logic                  match_set_c;
    logic                  irq_src_c;
    logic [DW-1:0]         status_c;
    logic [DW-1:0]         rdata_c;
    logic                  addr_unused;

    // Address bits above the register window are ignored by design
    assign addr_unused = ^s_apb_paddr[ADDRESS_WIDTH-1:OFF_WIDTH];

    // Address decode shared by setup-phase read/error capture and access-phase write
    assign offset_c     = {s_apb_paddr[OFF_WIDTH-1:2], 2'b00};
    assign aligned_c    = (s_apb_paddr[1:0] == 2'b00);
    assign mapped_c     = (offset_c <= OFF_STATUS) || (CAPTURE_EN && (offset_c == OFF_CAPTURE));
    assign err_c        = !aligned_c || !mapped_c || (s_apb_pwrite && (offset_c == OFF_CAPTURE));
    assign wr_en_c      = s_apb_psel && s_apb_penable && s_apb_pwrite && !err_c;
    assign status_w1c_c = wr_en_c && (offset_c == OFF_STATUS);
    assign count_load_c = wr_en_c && (offset_c == OFF_COUNT);

    assign s_apb_pready    = s_apb_psel && s_apb_penable;
    assign s_apb_prdata    = prdata_q;
    assign s_apb_pslverror = pslverror_q;
    assign irq             = irq_q;

    apb_timer_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .enable_i   (ctrl_q[CTRL_ENABLE]),
        .clear_i    (count_load_c),
        .prescale_i (prescale_q),
        .tick_o     (tick_c)
    );

`ifdef APB_TIMER_CAPTURE_EN
    logic [2:0]    cap_sync_q;
    logic          cap_edge_c;
    logic [DW-1:0] capture_q;
    logic          cap_flag_q, cap_flag_d;

    // cap_sync_q[1:0] is the synchroniser, cap_sync_q[2] the previous synchronised level
    assign cap_edge_c = cap_sync_q[1] && !cap_sync_q[2];
    // Hardware set wins over a same-cycle write-one-to-clear
    assign cap_flag_d = (cap_flag_q && !(status_w1c_c && s_apb_pwdata[STATUS_CAPTURE])) || cap_edge_c;
    assign irq_src_c  = match_q || cap_flag_q;

    // Synchronise capture_in and latch COUNT on its rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_sync_q <= '0;
            capture_q  <= '0;
            cap_flag_q <= 1'b0;
        end else begin
            cap_sync_q <= {cap_sync_q[1:0], capture_in};
            cap_flag_q <= cap_flag_d;
            if (cap_edge_c) begin
                capture_q <= count_q;
            end
        end
    end
`else
    assign irq_src_c = match_q;
`endif

    // STATUS read view
    always_comb begin
        status_c               = '0;
        status_c[STATUS_MATCH] = match_q;
`ifdef APB_TIMER_CAPTURE_EN
        status_c[STATUS_CAPTURE] = cap_flag_q;
`else
        status_c[STATUS_CAPTURE] = 1'b0;
`endif
    end

    // Read data mux; erroring accesses return zero
    always_comb begin
        rdata_c = '0;
        case (offset_c)
            OFF_CTRL:     rdata_c = DW'(ctrl_q);
            OFF_PRESCALE: rdata_c = DW'(prescale_q);
            OFF_COMPARE:  rdata_c = compare_q;
            OFF_COUNT:    rdata_c = count_q;
            OFF_STATUS:   rdata_c = status_c;
`ifdef APB_TIMER_CAPTURE_EN
            OFF_CAPTURE:  rdata_c = capture_q;
`endif
            default:      rdata_c = '0;
        endcase
        if (err_c) begin
            rdata_c = '0;
        end
    end

    // Counter/compare update followed by register writes, which take priority
    always_comb begin
        ctrl_d      = ctrl_q;
        prescale_d  = prescale_q;
        compare_d   = compare_q;
        count_d     = count_q;
        match_set_c = 1'b0;

        if (tick_c) begin
            if (count_q == compare_q) begin
                match_set_c = 1'b1;
                if (ctrl_q[CTRL_AUTO_RELOAD]) begin
                    count_d = '0;
                end else begin
                    ctrl_d[CTRL_ENABLE] = 1'b0;
                end
            end else begin
                count_d = count_q + DW'(1);
            end
        end

        if (wr_en_c) begin
            case (offset_c)
                OFF_CTRL:     ctrl_d     = s_apb_pwdata[CTRL_WIDTH-1:0];
                OFF_PRESCALE: prescale_d = s_apb_pwdata[PW-1:0];
                OFF_COMPARE:  compare_d  = s_apb_pwdata;
                OFF_COUNT:    count_d    = s_apb_pwdata;
                default:      ;
            endcase
        end

        // Hardware set wins over a same-cycle write-one-to-clear
        match_d = (match_q && !(status_w1c_c && s_apb_pwdata[STATUS_MATCH])) || match_set_c;
        irq_d   = ctrl_q[CTRL_IRQ_EN] && irq_src_c;
    end

    // Register file, APB response registers and IRQ
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q      <= '0;
            prescale_q  <= '0;
            compare_q   <= '0;
            count_q     <= '0;
            match_q     <= 1'b0;
            prdata_q    <= '0;
            pslverror_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            match_q    <= match_d;
            irq_q      <= irq_d;
            if (s_apb_psel && !s_apb_penable) begin
                prdata_q    <= rdata_c;
                pslverror_q <= err_c;
            end
        end
    end

endmodule

// File: tb/tb_apb_timer.sv
// Self-checking bench for apb_timer: directed register/error/W1C cases plus randomized
// timer runs checked against a closed-form model of the prescaled counter.
module tb_apb_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pready;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pslverror;
    logic        irq;
`ifdef APB_TIMER_CAPTURE_EN
    logic        capture_in;
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    apb_timer dut (
        .clk             (clk),
        .rst             (rst),
        .s_apb_paddr     (paddr),
        .s_apb_psel      (psel),
        .s_apb_penable   (penable),
        .s_apb_pready    (pready),
        .s_apb_pwrite    (pwrite),
        .s_apb_pwdata    (pwdata),
        .s_apb_prdata    (prdata),
        .s_apb_pslverror (pslverror),
`ifdef APB_TIMER_CAPTURE_EN
        .capture_in      (capture_in),
`endif
        .irq             (irq)
    );

    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc is the index of the posedge just passed
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the negedge after the access edge (cyc = commit edge)
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, input logic exp_err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(negedge clk);
        penable = 1'b1;
        #1;
        check($sformatf("wr_pready_%h", addr), 32'(pready), 32'd1);
        check($sformatf("wr_err_%h", addr), 32'(pslverror), 32'(exp_err));
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Called at a negedge; 'at' is the setup edge index, so data reflects state after at-1 edges
    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic err, output int unsigned at);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        @(negedge clk);
        penable = 1'b1;
        #1;
        check($sformatf("rd_pready_%h", addr), 32'(pready), 32'd1);
        data = prdata; err = pslverror; at = cyc;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    // Timer state after m edges since enable, counting from COUNT=0
    function automatic void model(input int unsigned m, input int unsigned p, input int unsigned c,
                                  input bit ar, output logic [31:0] cnt, output bit match, output bit en);
        int unsigned t;
        t     = m / (p + 1);
        match = (t >= c + 1);
        cnt   = ar ? 32'(t % (c + 1)) : 32'((t > c) ? c : t);
        en    = ar ? 1'b1 : !match;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  d, exp_cnt;
        logic         e;
        int unsigned  s, e0, p, c, wn;
        bit           ar, ie, exp_match, exp_en;

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
`ifdef APB_TIMER_CAPTURE_EN
        capture_in = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_prdata", prdata, 32'd0);
        check("rst_pslverror", 32'(pslverror), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;

        // All registers read zero after reset
        for (int a = 0; a < (CAP ? 6 : 5); a++) begin
            apb_read(32'(a * 4), d, e, s);
            check($sformatf("reset_rd_%0d", a), d, 32'd0);
            check($sformatf("reset_err_%0d", a), 32'(e), 32'd0);
            check($sformatf("reset_irq_%0d", a), 32'(irq), 32'd0);
        end

        // Randomized runs; the first is PRESCALE=3 COMPARE=5 auto-reload for 24 clocks
        for (int it = 0; it < 16; it++) begin
            p  = (it == 0) ? 3 : $urandom_range(0, 3);
            c  = (it == 0) ? 5 : $urandom_range(0, 6);
            ar = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            wn = (it == 0) ? 24 : $urandom_range(0, 40);
            apb_write(32'h00, 32'd0, 1'b0);
            apb_write(32'h0C, 32'd0, 1'b0);
            apb_write(32'h10, 32'd3, 1'b0);
            apb_write(32'h04, 32'(p), 1'b0);
            apb_write(32'h08, 32'(c), 1'b0);
            apb_write(32'h00, {29'd0, ie, ar, 1'b1}, 1'b0);
            e0 = cyc;
            repeat (wn) @(negedge clk);
            apb_read(32'h0C, d, e, s);
            model(s - 1 - e0, p, c, ar, exp_cnt, exp_match, exp_en);
            check($sformatf("it%0d_count", it), d, exp_cnt);
            apb_read(32'h10, d, e, s);
            model(s - 1 - e0, p, c, ar, exp_cnt, exp_match, exp_en);
            check($sformatf("it%0d_status", it), d, 32'(exp_match));
            check($sformatf("it%0d_irq", it), 32'(irq), 32'(ie & exp_match));
            apb_read(32'h00, d, e, s);
            model(s - 1 - e0, p, c, ar, exp_cnt, exp_match, exp_en);
            check($sformatf("it%0d_ctrl", it), d, {29'd0, ie, ar, exp_en});
        end

        // COUNT wraps from 0xFFFFFFFF to 0 without a match
        apb_write(32'h00, 32'd0, 1'b0);
        apb_write(32'h0C, 32'hFFFF_FFFD, 1'b0);
        apb_write(32'h10, 32'd3, 1'b0);
        apb_write(32'h04, 32'd0, 1'b0);
        apb_write(32'h08, 32'h100, 1'b0);
        apb_write(32'h00, 32'h3, 1'b0);
        e0 = cyc;
        repeat (4) @(negedge clk);
        apb_read(32'h0C, d, e, s);
        check("wrap_count", d, 32'hFFFF_FFFD + 32'(s - 1 - e0));
        apb_read(32'h10, d, e, s);
        check("wrap_status", d, 32'd0);

        // One-shot match coinciding with a W1C of STATUS.match
        apb_write(32'h00, 32'd0, 1'b0);
        apb_write(32'h0C, 32'd0, 1'b0);
        apb_write(32'h10, 32'd3, 1'b0);
        apb_write(32'h08, 32'd10, 1'b0);
        apb_write(32'h00, 32'h5, 1'b0);
        e0 = cyc;
        for (int k = 0; k < 20 && cyc != e0 + 9; k++) @(negedge clk);
        check("w1c_align", cyc, e0 + 9);
        apb_write(32'h10, 32'd1, 1'b0);
        check("w1c_commit_edge", cyc, e0 + 11);
        check("w1c_irq_before", 32'(irq), 32'd0);
        apb_read(32'h10, d, e, s);
        check("w1c_status_kept", d, 32'd1);
        check("oneshot_irq", 32'(irq), 32'd1);
        apb_read(32'h00, d, e, s);
        check("oneshot_ctrl", d, 32'h4);
        apb_read(32'h0C, d, e, s);
        check("oneshot_count", d, 32'd10);
        apb_write(32'h10, 32'd1, 1'b0);
        check("clear_irq_same", 32'(irq), 32'd1);
        @(negedge clk);
        check("clear_irq_next", 32'(irq), 32'd0);
        apb_read(32'h10, d, e, s);
        check("clear_status", d, 32'd0);

        // Error and decode cases
        apb_read(32'h18, d, e, s);
        check("unmapped_rd_err", 32'(e), 32'd1);
        check("unmapped_rd_data", d, 32'd0);
        apb_read(32'h1C, d, e, s);
        check("unmapped1c_err", 32'(e), 32'd1);
        apb_read(32'h02, d, e, s);
        check("misaligned_rd_err", 32'(e), 32'd1);
        check("misaligned_rd_data", d, 32'd0);
        apb_write(32'h02, 32'hFFFF_FFFF, 1'b1);
        apb_write(32'h14, 32'h1234_5678, 1'b1);
        apb_read(32'h00, d, e, s);
        check("bad_write_no_effect", d, 32'h4);
        apb_read(32'h100, d, e, s);
        check("upper_addr_ignored", d, 32'h4);
        check("upper_addr_err", 32'(e), 32'd0);
        apb_read(32'h14, d, e, s);
        check("capture_rd_err", 32'(e), 32'(!CAP));

`ifdef APB_TIMER_CAPTURE_EN
        // Capture edge at COUNT=7 lands COUNT=9 after synchronisation
        apb_write(32'h00, 32'd0, 1'b0);
        apb_write(32'h0C, 32'd0, 1'b0);
        apb_write(32'h10, 32'd3, 1'b0);
        apb_write(32'h08, 32'hFFFF, 1'b0);
        apb_write(32'h00, 32'h1, 1'b0);
        e0 = cyc;
        for (int k = 0; k < 20 && cyc != e0 + 7; k++) @(negedge clk);
        capture_in = 1'b1;
        @(negedge clk);
        capture_in = 1'b0;
        repeat (4) @(negedge clk);
        apb_read(32'h14, d, e, s);
        check("capture_value", d, 32'd9);
        apb_read(32'h10, d, e, s);
        check("capture_status", d, 32'h2);
        apb_write(32'h00, 32'd0, 1'b0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
